aud_btm_deframer: RTL and testbench
===================================

// Module: aud_btm_deframer
// PURPOSE
//  Branch-trace receive front end that feeds the AUD branch trace mode engine in aud_core.
//  Synchronises the raw AUD pins (aud_ck, aud_nsync, aud_data) into the clk_sys_i domain
//  and detects aud_ck rising edges. Assembles nibble frames into trace records and
//  presents them on a valid/ready stream, with sticky error/overflow flags and a frame counter.
// PARAMETERS
//  g_sync_stages  2   flip-flops in each input synchroniser; legal range 2..4
//  g_cnt_width    16  width of frame_cnt_o
// PORTS
//  clk_sys_i     in   1   system clock; the only clock in the block
//  rst_i         in   1   asynchronous, active-high reset
//  en_i          in   1   1 = receive; 0 = force IDLE and drop any partial frame
//  clr_i         in   1   1-cycle pulse; clears ovf_o, err_short_o, err_long_o
//  aud_ck_i      in   1   raw AUD clock pin (asynchronous)
//  aud_nsync_i   in   1   raw AUD sync pin, active-low frame marker (asynchronous)
//  aud_data_i    in   4   raw AUD data nibble (asynchronous)
//  rec_valid_o   out  1   trace record available
//  rec_ready_i   in   1   consumer accepts the record when rec_valid_o & rec_ready_i
//  rec_type_o    out  2   header bits [3:2]
//  rec_len_o     out  2   header bits [1:0]; payload = 1,2,4,8 nibbles for codes 0..3
//  rec_addr_o    out  32  assembled payload, zero-extended
//  ovf_o         out  1   sticky; a record was dropped
//  err_short_o   out  1   sticky; nsync rose before the payload was complete
//  err_long_o    out  1   sticky; extra nibble(s) arrived after a complete payload
//  frame_cnt_o   out  g_cnt_width  count of records accepted into the output register
// BEHAVIOUR
//  Reset: all outputs 0, FSM = IDLE, synchronisers 1 for ck/nsync and 0 for data.
//  Sync: ck, nsync and data each pass through g_sync_stages FFs, plus one delay FF on ck.
//   edge = ck_sync & ~ck_dly. nsync/data are taken from the synchroniser output on the edge cycle.
//   Pin-to-edge latency = g_sync_stages+1 clk_sys_i cycles.
//   aud_ck high and low phases must each be >= g_sync_stages+1 clk_sys_i periods.
//  FSM, advancing only on edge cycles; en_i=0 forces IDLE on any cycle, without setting flags:
//   IDLE:    nsync=0 -> latch type=data[3:2], len=data[1:0], clear shift reg and nib_cnt -> PAYLOAD.
//   PAYLOAD: nsync=0 -> addr[4*nib_cnt+:4]=data (LS nibble first); nib_cnt++.
//            On the last nibble (nib_cnt == N-1) -> emit record -> WAIT_END.
//            nsync=1 -> err_short_o=1, discard -> IDLE.
//   WAIT_END: nsync=0 -> err_long_o=1, nibble ignored, stay. nsync=1 -> IDLE.
//   Back-to-back: a frame may only start from IDLE, so >= 1 edge with nsync=1 separates frames.
//  Emit: the record register loads the cycle after the last-nibble edge.
//   rec_valid_o rises in that same cycle; frame_cnt_o increments and wraps modulo 2^g_cnt_width.
//   Bits of rec_addr_o above 4*N are 0.
//  Handshake: rec_valid_o stays high and the record stays stable until rec_valid_o&rec_ready_i.
//   rec_valid_o drops the cycle after acceptance unless a new record loads in that cycle.
//  Emit while rec_valid_o & ~rec_ready_i: the new record is dropped, ovf_o=1, frame_cnt_o unchanged.
//  Emit in the same cycle as acceptance: the old record goes out, the new one loads, no overflow.
//  clr_i and a flag set in the same cycle: the set wins and the flag stays 1.
//  rst_i mid-frame: immediate return to reset state; the partial frame is lost.
// TESTING
//  T1 hdr=4'b0111, nibbles 1..8 (1 to 8), ready=1 -> one record: type=1, len=3, addr=32'h87654321, cnt=1.
//  T2 hdr=4'b0000, nibble A -> addr=32'h0000000A, len=0; then hdr=4'b1101 + 2 nibbles 3,C -> addr=32'h000000C3.
//  T3 hdr len=2, nsync rises after 2 of 4 nibbles -> no record, err_short_o=1; clr_i pulse -> 0.
//  T4 hdr len=1 + 3 nibbles with nsync low -> record addr from the first 2 nibbles, err_long_o=1.
//  T5 ready=0, two complete frames -> first record held, ovf_o=1, cnt=1; ready=1 -> accepted.
//  T6 rst_i asserted mid-PAYLOAD, then en_i=0 mid-frame -> no record, flags 0, next frame decodes.

Source files
------------

// File: rtl/aud_btm_deframer.sv
// AUD branch-trace deframer: synchronises the raw AUD pins, assembles header/payload nibble
// frames into trace records and presents them on a valid/ready stream with sticky flags.
module aud_btm_deframer #(
  parameter int unsigned g_sync_stages = 2,
  parameter int unsigned g_cnt_width   = 16
) (
  input  logic                   clk_sys_i,
  input  logic                   rst_i,
  input  logic                   en_i,
  input  logic                   clr_i,
  input  logic                   aud_ck_i,
  input  logic                   aud_nsync_i,
  input  logic [3:0]             aud_data_i,
  output logic                   rec_valid_o,
  input  logic                   rec_ready_i,
  output logic [1:0]             rec_type_o,
  output logic [1:0]             rec_len_o,
  output logic [31:0]            rec_addr_o,
  output logic                   ovf_o,
  output logic                   err_short_o,
  output logic                   err_long_o,
  output logic [g_cnt_width-1:0] frame_cnt_o
);

  typedef enum logic [1:0] {StIdle, StPayload, StWaitEnd} state_e;

  logic [g_sync_stages-1:0]      ck_sync_q;
  logic [g_sync_stages-1:0]      nsync_sync_q;
  logic [g_sync_stages-1:0][3:0] data_sync_q;
  logic                          ck_dly_q;

  logic       ck_s, nsync_s, edge_s;
  logic [3:0] data_s;

  state_e     state_q;
  logic [1:0] hdr_type_q, hdr_len_q;
  logic [2:0] nib_cnt_q;
  logic [31:0] shift_q;

  logic        last_nib;
  logic        emit;
  logic [31:0] addr_full;
  logic [2:0]  last_idx;

  // Synchronisers idle at the pin-inactive levels so reset cannot fake an edge or a sync.
  always_ff @(posedge clk_sys_i or posedge rst_i) begin
    if (rst_i) begin
      ck_sync_q    <= '1;
      nsync_sync_q <= '1;
      data_sync_q  <= '0;
      ck_dly_q     <= 1'b1;
    end else begin
      ck_sync_q    <= {ck_sync_q[g_sync_stages-2:0], aud_ck_i};
      nsync_sync_q <= {nsync_sync_q[g_sync_stages-2:0], aud_nsync_i};
      data_sync_q  <= {data_sync_q[g_sync_stages-2:0], aud_data_i};
      ck_dly_q     <= ck_s;
    end
  end

  assign ck_s    = ck_sync_q[g_sync_stages-1];
  assign nsync_s = nsync_sync_q[g_sync_stages-1];
  assign data_s  = data_sync_q[g_sync_stages-1];
  assign edge_s  = ck_s & ~ck_dly_q;

  always_comb begin
    last_idx  = 3'((4'd1 << hdr_len_q) - 4'd1);
    last_nib  = (nib_cnt_q == last_idx);
    addr_full = shift_q | ({28'd0, data_s} << {nib_cnt_q, 2'b00});
    emit      = en_i & edge_s & (state_q == StPayload) & ~nsync_s & last_nib;
  end

  always_ff @(posedge clk_sys_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      hdr_type_q  <= '0;
      hdr_len_q   <= '0;
      nib_cnt_q   <= '0;
      shift_q     <= '0;
      rec_valid_o <= 1'b0;
      rec_type_o  <= '0;
      rec_len_o   <= '0;
      rec_addr_o  <= '0;
      ovf_o       <= 1'b0;
      err_short_o <= 1'b0;
      err_long_o  <= 1'b0;
      frame_cnt_o <= '0;
    end else begin
      // Clear first so a same-cycle flag set below takes priority.
      if (clr_i) begin
        ovf_o       <= 1'b0;
        err_short_o <= 1'b0;
        err_long_o  <= 1'b0;
      end

      if (!en_i) begin
        state_q <= StIdle;
      end else if (edge_s) begin
        unique case (state_q)
          StIdle: begin
            if (!nsync_s) begin
              hdr_type_q <= data_s[3:2];
              hdr_len_q  <= data_s[1:0];
              nib_cnt_q  <= '0;
              shift_q    <= '0;
              state_q    <= StPayload;
            end
          end
          StPayload: begin
            if (nsync_s) begin
              err_short_o <= 1'b1;
              state_q     <= StIdle;
            end else begin
              shift_q   <= addr_full;
              nib_cnt_q <= nib_cnt_q + 3'd1;
              if (last_nib) state_q <= StWaitEnd;
            end
          end
          StWaitEnd: begin
            if (nsync_s) state_q <= StIdle;
            else         err_long_o <= 1'b1;
          end
          default: state_q <= StIdle;
        endcase
      end

      if (emit) begin
        if (!rec_valid_o || rec_ready_i) begin
          rec_valid_o <= 1'b1;
          rec_type_o  <= hdr_type_q;
          rec_len_o   <= hdr_len_q;
          rec_addr_o  <= addr_full;
          frame_cnt_o <= frame_cnt_o + 1'b1;
        end else begin
          ovf_o <= 1'b1;
        end
      end else if (rec_valid_o && rec_ready_i) begin
        rec_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_aud_btm_deframer.sv
// Directed bench for aud_btm_deframer: a frame-level model predicts records and flags, one
// process checks every handshake and held record, and literal expectations pin the model.
module tb_aud_btm_deframer;

  logic        clk = 1'b0;
  logic        rst, en, clr, aud_ck, aud_nsync, rec_ready;
  logic [3:0]  aud_data;
  logic        rec_valid, ovf, err_short, err_long;
  logic [1:0]  rec_type, rec_len;
  logic [31:0] rec_addr;
  logic [15:0] frame_cnt;

  always #5 clk = ~clk;

  aud_btm_deframer #(.g_sync_stages(2), .g_cnt_width(16)) dut (
    .clk_sys_i(clk), .rst_i(rst), .en_i(en), .clr_i(clr),
    .aud_ck_i(aud_ck), .aud_nsync_i(aud_nsync), .aud_data_i(aud_data),
    .rec_valid_o(rec_valid), .rec_ready_i(rec_ready), .rec_type_o(rec_type),
    .rec_len_o(rec_len), .rec_addr_o(rec_addr), .ovf_o(ovf), .err_short_o(err_short),
    .err_long_o(err_long), .frame_cnt_o(frame_cnt)
  );

  int total = 0;
  int bad   = 0;

  // Model state: expected records in output order, expected sticky flags and count.
  logic [35:0] exp_q[$];
  logic        m_ovf, m_short, m_long;
  logic [15:0] m_cnt;
  logic [35:0] last_got;
  logic [3:0]  nb[16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One aud_ck period; pins change only while aud_ck is low.
  task automatic pin_edge(input logic ns, input logic [3:0] d);
    aud_nsync = ns;
    aud_data  = d;
    cyc(4);
    aud_ck = 1'b1;
    cyc(4);
    aud_ck = 1'b0;
  endtask

  task automatic send_nibs(input int n);
    for (int i = 0; i < n; i++) pin_edge(1'b0, nb[i]);
  endtask

  // Predict the outcome of a frame of n nibbles (header + payload) held in nb.
  task automatic model_frame(input int n);
    int unsigned need;
    logic [31:0] a;
    need = 1 << nb[0][1:0];
    if (n - 1 < int'(need)) begin
      m_short = 1'b1;
    end else begin
      a = '0;
      for (int i = 0; i < int'(need); i++) a |= 32'(nb[i + 1]) << (4 * i);
      if (n - 1 > int'(need)) m_long = 1'b1;
      if (exp_q.size() > 0 && !rec_ready) m_ovf = 1'b1;
      else begin
        exp_q.push_back({nb[0], a});
        m_cnt++;
      end
    end
  endtask

  task automatic frame(input int n);
    model_frame(n);
    send_nibs(n);
    pin_edge(1'b1, 4'h0);
    cyc(6);
  endtask

  task automatic checkpoint(input string tag);
    chk({tag, "_ovf"}, 64'(ovf), 64'(m_ovf));
    chk({tag, "_short"}, 64'(err_short), 64'(m_short));
    chk({tag, "_long"}, 64'(err_long), 64'(m_long));
    chk({tag, "_cnt"}, 64'(frame_cnt), 64'(m_cnt));
    chk({tag, "_valid"}, 64'(rec_valid), 64'(exp_q.size() != 0));
  endtask

  task automatic clear_flags();
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    {m_ovf, m_short, m_long} = '0;
    cyc(1);
  endtask

  // Compare process: every handshake against the model, every held record for stability.
  logic        prev_hold;
  logic [35:0] prev_rec;
  always @(negedge clk) begin
    if (rst) begin
      prev_hold <= 1'b0;
    end else begin
      if (prev_hold) begin
        chk("hold_valid", 64'(rec_valid), 64'd1);
        chk("hold_rec", 64'({rec_type, rec_len, rec_addr}), 64'(prev_rec));
      end
      if (rec_valid && rec_ready) begin
        last_got = {rec_type, rec_len, rec_addr};
        if (exp_q.size() == 0) chk("spurious_rec", 64'(last_got), 64'hFFFF_FFFF_FFFF);
        else chk("rec", 64'(last_got), 64'(exp_q.pop_front()));
      end
      prev_hold <= rec_valid & ~rec_ready;
      prev_rec  <= {rec_type, rec_len, rec_addr};
    end
  end

  initial begin
    rst = 1'b1; en = 1'b1; clr = 1'b0; rec_ready = 1'b1;
    aud_ck = 1'b0; aud_nsync = 1'b1; aud_data = 4'h0;
    {m_ovf, m_short, m_long} = '0;
    m_cnt = '0;
    last_got = '0;
    cyc(3);
    chk("rst_valid", 64'(rec_valid), 64'd0);
    chk("rst_rec", 64'({rec_type, rec_len, rec_addr}), 64'd0);
    chk("rst_flags", 64'({ovf, err_short, err_long}), 64'd0);
    chk("rst_cnt", 64'(frame_cnt), 64'd0);
    rst = 1'b0;
    cyc(4);

    // T1: len 3 -> 8 nibbles
    nb[0] = 4'b0111;
    for (int i = 1; i <= 8; i++) nb[i] = 4'(i);
    frame(9);
    checkpoint("t1");
    chk("t1_lit", 64'(last_got), 64'({2'd1, 2'd3, 32'h8765_4321}));

    // T2: single-nibble then two-nibble payload
    nb[0] = 4'b0000; nb[1] = 4'hA;
    frame(2);
    checkpoint("t2a");
    chk("t2a_lit", 64'(last_got), 64'({2'd0, 2'd0, 32'h0000_000A}));
    nb[0] = 4'b1101; nb[1] = 4'h3; nb[2] = 4'hC;
    frame(3);
    checkpoint("t2b");
    chk("t2b_lit", 64'(last_got), 64'({2'd3, 2'd1, 32'h0000_00C3}));

    // T3: short payload
    nb[0] = 4'b0110; nb[1] = 4'h1; nb[2] = 4'h2;
    frame(3);
    checkpoint("t3");
    chk("t3_short_lit", 64'(err_short), 64'd1);
    clear_flags();
    checkpoint("t3_clr");

    // T4: one extra nibble after a complete payload
    nb[0] = 4'b1001; nb[1] = 4'h5; nb[2] = 4'h6; nb[3] = 4'h7;
    frame(4);
    checkpoint("t4");
    chk("t4_lit", 64'(last_got), 64'({2'd2, 2'd1, 32'h0000_0065}));
    clear_flags();

    // T5: consumer stalled across two frames
    rec_ready = 1'b0;
    nb[0] = 4'b0101; nb[1] = 4'h9; nb[2] = 4'hE;
    frame(3);
    nb[0] = 4'b0000; nb[1] = 4'h4;
    frame(2);
    checkpoint("t5_held");
    chk("t5_held_addr", 64'(rec_addr), 64'h0000_00E9);
    rec_ready = 1'b1;
    cyc(3);
    checkpoint("t5_acc");
    chk("t5_lit", 64'(last_got), 64'({2'd1, 2'd1, 32'h0000_00E9}));
    clear_flags();

    // T6: reset mid-payload, then disable mid-frame
    nb[0] = 4'b0011; nb[1] = 4'hF;
    send_nibs(2);
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    exp_q.delete();
    {m_ovf, m_short, m_long} = '0;
    m_cnt = '0;
    pin_edge(1'b1, 4'h0);
    cyc(6);
    checkpoint("t6_rst");
    send_nibs(3);
    en = 1'b0;
    cyc(2);
    en = 1'b1;
    pin_edge(1'b1, 4'h0);
    cyc(6);
    checkpoint("t6_en");
    nb[0] = 4'b1110; nb[1] = 4'h1; nb[2] = 4'h2; nb[3] = 4'h3; nb[4] = 4'h4;
    frame(5);
    checkpoint("t6_next");
    chk("t6_lit", 64'(last_got), 64'({2'd3, 2'd2, 32'h0000_4321}));
    chk("drain", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
